// File: rtl/tdisplay_scan.sv
// Scan driver for an 8-digit common-anode display: shows a signed 4-digit BCD temperature
// plus a C/F unit letter, one digit slot at a time, with a blank guard at each slot start.
module tdisplay_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       c_f,
    input  logic       sign,
    input  logic [3:0] thou,
    input  logic [3:0] hund,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);

    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic          load_pending;
    logic          tick;
    logic          capture;

    logic       sh_c_f;
    logic       sh_sign;
    logic [3:0] sh_thou;
    logic [3:0] sh_hund;
    logic [3:0] sh_tens;
    logic [3:0] sh_ones;

    logic       thou_blank;
    logic       hund_blank;
    logic       tens_blank;
    logic [7:0] slot_an;
    logic [6:0] slot_seg;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0:    digit_seg = 7'h40;
            4'd1:    digit_seg = 7'h79;
            4'd2:    digit_seg = 7'h24;
            4'd3:    digit_seg = 7'h30;
            4'd4:    digit_seg = 7'h19;
            4'd5:    digit_seg = 7'h12;
            4'd6:    digit_seg = 7'h02;
            4'd7:    digit_seg = 7'h78;
            4'd8:    digit_seg = 7'h00;
            4'd9:    digit_seg = 7'h10;
            default: digit_seg = SEG_E;
        endcase
    endfunction

    assign tick    = (presc == PRESC_LAST);
    // Inputs are only sampled at a frame boundary so a frame never mixes two values.
    assign capture = (tick && idx == 3'd5) || load_pending;
    assign dp      = 1'b1;

    assign thou_blank = (sh_thou == 4'd0);
    assign hund_blank = thou_blank && (sh_hund == 4'd0);
    assign tens_blank = hund_blank && (sh_tens == 4'd0);

    always_comb begin
        slot_an  = 8'hFF;
        slot_seg = SEG_BLANK;
        case (idx)
            3'd0: begin
                slot_an  = 8'hFE;
                slot_seg = sh_c_f ? SEG_F : SEG_C;
            end
            3'd1: begin
                slot_an  = 8'hFD;
                slot_seg = digit_seg(sh_ones);
            end
            3'd2: begin
                slot_an  = 8'hFB;
                slot_seg = tens_blank ? SEG_BLANK : digit_seg(sh_tens);
            end
            3'd3: begin
                slot_an  = 8'hF7;
                slot_seg = hund_blank ? SEG_BLANK : digit_seg(sh_hund);
            end
            3'd4: begin
                slot_an  = 8'hEF;
                slot_seg = thou_blank ? SEG_BLANK : digit_seg(sh_thou);
            end
            3'd5: begin
                slot_an  = 8'hDF;
                slot_seg = sh_sign ? SEG_MINUS : SEG_BLANK;
            end
            default: begin
                slot_an  = 8'hFF;
                slot_seg = SEG_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc        <= '0;
            idx          <= 3'd0;
            load_pending <= 1'b1;
            sh_c_f       <= 1'b0;
            sh_sign      <= 1'b0;
            sh_thou      <= 4'd0;
            sh_hund      <= 4'd0;
            sh_tens      <= 4'd0;
            sh_ones      <= 4'd0;
            an           <= 8'hFF;
            seg          <= SEG_BLANK;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end
            if (capture) begin
                load_pending <= 1'b0;
                sh_c_f       <= c_f;
                sh_sign      <= sign;
                sh_thou      <= thou;
                sh_hund      <= hund;
                sh_tens      <= tens;
                sh_ones      <= ones;
            end
            // Guard tracks presc, so every slot change is preceded by all-anodes-off.
            if (presc < GUARD_END) begin
                an  <= 8'hFF;
                seg <= SEG_BLANK;
            end else begin
                an  <= slot_an;
                seg <= slot_seg;
            end
        end
    end
endmodule

// File: tb/tb_tdisplay_scan.sv
// Bench for tdisplay_scan: directed display scenarios plus randomized inputs and resets,
// checked every cycle against a cycle-count based model of the scan.
module tb_tdisplay_scan;
    localparam int DIV   = 4;
    localparam int GRD   = 1;
    localparam int FRAME = 6 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       c_f;
    logic       sign;
    logic [3:0] thou;
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_tests = 0;
    int n_fail  = 0;
    logic mon_en = 1'b0;

    tdisplay_scan #(.REFRESH_DIV(DIV), .GUARD(GRD)) dut (
        .clk(clk), .rst(rst), .c_f(c_f), .sign(sign),
        .thou(thou), .hund(hund), .tens(tens), .ones(ones),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: position in the scan follows from cycles since reset release.
    int         k;
    logic [3:0] m_d[4];
    logic       m_sign;
    logic       m_cf;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;

    function automatic logic [6:0] digit_code(input logic [3:0] d);
        logic [6:0] tbl[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (d > 4'd9) return 7'h06;
        return tbl[d];
    endfunction

    function automatic logic [6:0] model_code(input int slot);
        int lead;
        lead = 1;
        for (int p = 2; p <= 4; p++) if (m_d[p-1] != 4'd0) lead = p;
        if (slot == 0) return m_cf ? 7'h0E : 7'h46;
        if (slot == 5) return m_sign ? 7'h3F : 7'h7F;
        if (slot > lead) return 7'h7F;
        return digit_code(m_d[slot-1]);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            k = 0;
            for (int i = 0; i < 4; i++) m_d[i] = 4'd0;
            m_sign  = 1'b0;
            m_cf    = 1'b0;
            exp_an  = 8'hFF;
            exp_seg = 7'h7F;
        end else begin
            if ((k % DIV) < GRD) begin
                exp_an  = 8'hFF;
                exp_seg = 7'h7F;
            end else begin
                exp_an = 8'hFF;
                exp_an[(k / DIV) % 6] = 1'b0;
                exp_seg = model_code((k / DIV) % 6);
            end
            if (k == 0 || (k % FRAME) == FRAME - 1) begin
                m_d[0] = ones; m_d[1] = tens; m_d[2] = hund; m_d[3] = thou;
                m_sign = sign;
                m_cf   = c_f;
            end
            k = k + 1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("an", an, exp_an);
            check("seg", seg, exp_seg);
            check("dp", dp, 1'b1);
            check("an_hi", an[7:6], 2'b11);
            check("an_onecold", ($countones(~an) <= 1), 1'b1);
        end
    end

    logic [6:0] seen[6];
    logic [7:0] first_an;

    task automatic collect(input int n);
        for (int i = 0; i < 6; i++) seen[i] = 7'h55;
        first_an = 8'hFF;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (an != 8'hFF) begin
                if (first_an == 8'hFF) first_an = an;
                for (int s = 0; s < 6; s++) if (!an[s]) seen[s] = seg;
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3,
                               input logic [6:0] e4, input logic [6:0] e5);
        check({tag, "_s0"}, seen[0], e0);
        check({tag, "_s1"}, seen[1], e1);
        check({tag, "_s2"}, seen[2], e2);
        check({tag, "_s3"}, seen[3], e3);
        check({tag, "_s4"}, seen[4], e4);
        check({tag, "_s5"}, seen[5], e5);
    endtask

    task automatic restart(input logic cf, input logic sg, input logic [3:0] t,
                           input logic [3:0] h, input logic [3:0] te, input logic [3:0] o);
        rst = 1'b1;
        c_f = cf; sign = sg; thou = t; hund = h; tens = te; ones = o;
        repeat (3) @(negedge clk);
        check("rst_an", an, 8'hFF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        rst = 1'b0;
    endtask

    function automatic logic [3:0] rand_digit();
        if ($urandom_range(0, 2) == 0) return 4'd0;
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        rst = 1'b1;
        c_f = 1'b0; sign = 1'b0;
        thou = 4'd0; hund = 4'd0; tens = 4'd0; ones = 4'd0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        restart(1'b0, 1'b0, 4'd0, 4'd0, 4'd5, 4'd0);
        collect(FRAME);
        check_frame("c50", 7'h46, 7'h40, 7'h12, 7'h7F, 7'h7F, 7'h7F);
        check("first_slot", first_an, 8'hFE);

        restart(1'b0, 1'b1, 4'd0, 4'd0, 4'd4, 4'd0);
        collect(FRAME);
        check_frame("neg40", 7'h46, 7'h40, 7'h19, 7'h7F, 7'h7F, 7'h3F);

        restart(1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0);
        collect(FRAME);
        check_frame("f1000", 7'h0E, 7'h40, 7'h40, 7'h40, 7'h79, 7'h7F);

        restart(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        collect(FRAME);
        check_frame("zero", 7'h46, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

        // Change tens while slot 2 is on the display.
        restart(1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 4'd1);
        collect(10);
        tens = 4'd7;
        collect(FRAME - 10);
        check("coh_old", seen[2], 7'h30);
        collect(FRAME);
        check("coh_new", seen[2], 7'h78);

        // Invalid BCD, then reset while slot 3 is active.
        restart(1'b0, 1'b0, 4'd0, 4'hC, 4'd0, 4'd2);
        collect(FRAME);
        check_frame("bad", 7'h46, 7'h24, 7'h40, 7'h06, 7'h7F, 7'h7F);
        collect(14);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_an", an, 8'hFF);
        check("midrst_seg", seg, 7'h7F);
        rst = 1'b0;
        collect(FRAME);
        check("midrst_first", first_an, 8'hFE);
        check_frame("midrst", 7'h46, 7'h24, 7'h40, 7'h06, 7'h7F, 7'h7F);

        // Randomized inputs with occasional resets.
        for (int it = 0; it < 50; it++) begin
            c_f  = 1'($urandom_range(0, 1));
            sign = 1'($urandom_range(0, 1));
            thou = rand_digit();
            hund = rand_digit();
            tens = rand_digit();
            ones = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                rst = 1'b0;
            end
            repeat ($urandom_range(1, 60)) @(negedge clk);
        end

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
